// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller: accepts one decoded op, holds the ALU operands
// until done, then presents result/flags to writeback and accumulates FP flags.
module alu_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TAG_W          = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_float,
    input  logic [31:0]      in_data1,
    input  logic [31:0]      in_data2,
    input  logic [31:0]      in_data3,
    input  logic [4:0]       in_alusel,
    input  logic [2:0]       in_rm,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [2:0]       frm_csr,
    input  logic             flush,
    output logic             alu_float_inst,
    output logic [31:0]      alu_data1,
    output logic [31:0]      alu_data2,
    output logic [31:0]      alu_data3,
    output logic [4:0]       alu_sel,
    output logic [2:0]       alu_rm,
    input  logic [31:0]      alu_result,
    input  logic [4:0]       alu_flags,
    input  logic             alu_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [4:0]       out_flags,
    output logic             out_illegal,
    output logic             out_timeout,
    output logic [4:0]       fflags_acc,
    input  logic             fflags_clr,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    // Handshakes: a transfer happens on a rising clk edge where valid && ready.
    // The source holds valid and payload stable until that edge; ready never
    // waits on valid. A flush in RESP withdraws out_valid with no transfer.

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, EXEC, DRAIN, RESP} state_t;

    state_t             state, state_nx;
    logic               float_q, illegal_q, timeout_q;
    logic [31:0]        d1_q, d2_q, d3_q, result_q;
    logic [4:0]         sel_q, flags_q, acc_q;
    logic [2:0]         rm_q, rm_res;
    logic [TAG_W-1:0]   tag_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               rm_bad, drive, hs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        out_valid = 1'b0;
        drive = 1'b0;
        rm_res = (in_rm == 3'b111) ? frm_csr : in_rm;
        rm_bad = in_float && (rm_res >= 3'd5);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = rm_bad ? RESP : EXEC;
            end
            EXEC: begin
                drive = 1'b1;
                if (alu_done)              state_nx = RESP;
                else if (flush)            state_nx = DRAIN;
                else if (cnt_q == CNT_LAST) state_nx = RESP;
            end
            DRAIN: begin
                drive = 1'b1;
                if (alu_done) state_nx = IDLE;
            end
            RESP: begin
                out_valid = 1'b1;
                if (flush || out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        hs = out_valid && out_ready && !flush;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            float_q   <= 1'b0;
            d1_q      <= '0;
            d2_q      <= '0;
            d3_q      <= '0;
            sel_q     <= '0;
            rm_q      <= '0;
            tag_q     <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    float_q   <= in_float;
                    d1_q      <= in_data1;
                    d2_q      <= in_data2;
                    d3_q      <= in_data3;
                    sel_q     <= in_alusel;
                    rm_q      <= rm_res;
                    tag_q     <= in_tag;
                    illegal_q <= rm_bad;
                    timeout_q <= 1'b0;
                    result_q  <= '0;
                    flags_q   <= '0;
                    cnt_q     <= '0;
                end
                EXEC: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (alu_done) begin
                        result_q <= alu_result;
                        flags_q  <= float_q ? alu_flags : 5'b0;
                    end else if (!flush && cnt_q == CNT_LAST) begin
                        result_q  <= '0;
                        flags_q   <= '0;
                        timeout_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A clear in the same cycle as an accumulate leaves exactly the new flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 acc_q <= '0;
        else if (fflags_clr)      acc_q <= (hs && float_q) ? flags_q : 5'b0;
        else if (hs && float_q)   acc_q <= acc_q | flags_q;
    end

    assign alu_float_inst = drive ? float_q : 1'b0;
    assign alu_data1      = drive ? d1_q : 32'b0;
    assign alu_data2      = drive ? d2_q : 32'b0;
    assign alu_data3      = drive ? d3_q : 32'b0;
    assign alu_sel        = drive ? sel_q : 5'b0;
    assign alu_rm         = drive ? rm_q : 3'b0;

    assign out_result  = result_q;
    assign out_tag     = tag_q;
    assign out_flags   = flags_q;
    assign out_illegal = illegal_q;
    assign out_timeout = timeout_q;
    assign fflags_acc  = acc_q;
    assign busy        = (state != IDLE);
    assign state_dbg   = state;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: plays decode, ALU and writeback; checks against a
// behavioural model of rounding-mode resolution, result capture and flag accumulation.
module tb_alu_issue_ctrl;
    localparam int TAG_W = 5;
    localparam int TMO   = 8;

    logic             clk, rst;
    logic             in_valid, in_ready, in_float;
    logic [31:0]      in_data1, in_data2, in_data3;
    logic [4:0]       in_alusel;
    logic [2:0]       in_rm, frm_csr;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             alu_float_inst;
    logic [31:0]      alu_data1, alu_data2, alu_data3;
    logic [4:0]       alu_sel;
    logic [2:0]       alu_rm;
    logic [31:0]      alu_result;
    logic [4:0]       alu_flags;
    logic             alu_done;
    logic             out_valid, out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic [4:0]       out_flags;
    logic             out_illegal, out_timeout;
    logic [4:0]       fflags_acc;
    logic             fflags_clr, busy;
    logic [1:0]       state_dbg;

    int         total_cnt = 0;
    int         pass_cnt  = 0;
    logic [4:0] exp_acc   = 5'b0;

    alu_issue_ctrl #(.TIMEOUT_CYCLES(TMO), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_float(in_float),
        .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
        .in_alusel(in_alusel), .in_rm(in_rm), .in_tag(in_tag), .frm_csr(frm_csr),
        .flush(flush),
        .alu_float_inst(alu_float_inst), .alu_data1(alu_data1), .alu_data2(alu_data2),
        .alu_data3(alu_data3), .alu_sel(alu_sel), .alu_rm(alu_rm),
        .alu_result(alu_result), .alu_flags(alu_flags), .alu_done(alu_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_tag(out_tag), .out_flags(out_flags), .out_illegal(out_illegal),
        .out_timeout(out_timeout), .fflags_acc(fflags_acc), .fflags_clr(fflags_clr),
        .busy(busy), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic drive_issue(input logic fl, input logic [31:0] d1, d2, d3,
                               input logic [4:0] sel, input logic [2:0] rm, frm,
                               input logic [TAG_W-1:0] tag);
        @(negedge clk);
        in_valid = 1'b1; in_float = fl;
        in_data1 = d1; in_data2 = d2; in_data3 = d3;
        in_alusel = sel; in_rm = rm; frm_csr = frm; in_tag = tag;
        @(negedge clk);
        in_valid = 1'b0;
        in_data1 = $urandom; in_data2 = $urandom; in_data3 = $urandom;
        in_rm = 3'($urandom); frm_csr = 3'($urandom); in_float = 1'($urandom);
    endtask

    // Behavioural ALU used to make up plausible results.
    function automatic logic [31:0] alu_ref(input logic [4:0] sel, input logic [31:0] a, b, c);
        if (sel[4]) return a * b;
        else if (sel[2:0] == 3'd0) return a + b;
        else return (a ^ b) + c;
    endfunction

    // One complete operation with checks on issue, EXEC hold, RESP and handshake.
    task automatic do_op(input logic fl, input logic [31:0] d1, d2, d3,
                         input logic [4:0] sel, input logic [2:0] rm, frm,
                         input logic [TAG_W-1:0] tag, input int done_dly, rdy_dly,
                         input logic [31:0] res, input logic [4:0] flg, input logic clr);
        logic [2:0]  rm_res;
        logic        ill;
        logic [31:0] exp_res;
        logic [4:0]  exp_flg;
        rm_res  = (rm == 3'b111) ? frm : rm;
        ill     = fl && (rm_res == 3'd5 || rm_res == 3'd6 || rm_res == 3'd7);
        exp_res = ill ? 32'b0 : res;
        exp_flg = (ill || !fl) ? 5'b0 : flg;

        @(negedge clk);
        total_cnt++;
        if ({in_ready, alu_float_inst} !== 2'b10)
            $display("FAIL idle_ready: got %b expected 10", {in_ready, alu_float_inst});
        else pass_cnt++;
        in_valid = 1'b1; in_float = fl;
        in_data1 = d1; in_data2 = d2; in_data3 = d3;
        in_alusel = sel; in_rm = rm; frm_csr = frm; in_tag = tag;
        @(negedge clk);
        in_valid = 1'b0;
        in_data1 = $urandom; in_data2 = $urandom; in_data3 = $urandom;
        frm_csr = 3'($urandom);

        if (!ill) begin
            for (int i = 0; i <= done_dly; i++) begin
                total_cnt++;
                if ({alu_float_inst, alu_data1, alu_data2, alu_data3, alu_sel, alu_rm, busy, out_valid}
                    !== {fl, d1, d2, d3, sel, rm_res, 1'b1, 1'b0})
                    $display("FAIL exec_hold[%0d]: got f=%b d=%h/%h/%h sel=%h rm=%h busy=%b ov=%b expected f=%b d=%h/%h/%h sel=%h rm=%h busy=1 ov=0",
                             i, alu_float_inst, alu_data1, alu_data2, alu_data3, alu_sel, alu_rm, busy, out_valid,
                             fl, d1, d2, d3, sel, rm_res);
                else pass_cnt++;
                alu_done   = (i == done_dly);
                alu_result = (i == done_dly) ? res : $urandom;
                alu_flags  = (i == done_dly) ? flg : 5'($urandom);
                @(negedge clk);
            end
            alu_done = 1'b0;
            alu_result = $urandom;
            alu_flags = 5'($urandom);
        end

        for (int j = 0; j <= rdy_dly; j++) begin
            total_cnt++;
            if ({out_valid, out_result, out_flags, out_tag, out_illegal, out_timeout,
                 alu_float_inst, alu_sel, alu_data1, in_ready}
                !== {1'b1, exp_res, exp_flg, tag, ill, 1'b0, 1'b0, 5'b0, 32'b0, 1'b0})
                $display("FAIL resp[%0d]: got ov=%b res=%h flg=%b tag=%h ill=%b to=%b af=%b asel=%h ad1=%h rdy=%b expected ov=1 res=%h flg=%b tag=%h ill=%b to=0 af=0 asel=0 ad1=0 rdy=0",
                         j, out_valid, out_result, out_flags, out_tag, out_illegal, out_timeout,
                         alu_float_inst, alu_sel, alu_data1, in_ready, exp_res, exp_flg, tag, ill);
            else pass_cnt++;
            if (j == rdy_dly) begin
                out_ready  = 1'b1;
                fflags_clr = clr;
                if (clr) exp_acc = exp_flg;
                else     exp_acc = exp_acc | exp_flg;
            end
            @(negedge clk);
        end
        out_ready = 1'b0; fflags_clr = 1'b0;
        total_cnt++;
        if ({out_valid, busy, in_ready, fflags_acc} !== {1'b0, 1'b0, 1'b1, exp_acc})
            $display("FAIL after_hs: got ov=%b busy=%b rdy=%b acc=%b expected ov=0 busy=0 rdy=1 acc=%b",
                     out_valid, busy, in_ready, fflags_acc, exp_acc);
        else pass_cnt++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({busy, in_ready, out_valid, out_result, out_flags, out_tag, out_illegal,
             out_timeout, fflags_acc, alu_float_inst, alu_data1, alu_sel, alu_rm}
            !== {1'b0, 1'b1, 1'b0, 32'b0, 5'b0, 5'b0, 1'b0, 1'b0, 5'b0, 1'b0, 32'b0, 5'b0, 3'b0})
            $display("FAIL reset: got busy=%b rdy=%b ov=%b res=%h acc=%b ad1=%h expected busy=0 rdy=1 ov=0 res=0 acc=0 ad1=0",
                     busy, in_ready, out_valid, out_result, fflags_acc, alu_data1);
        else pass_cnt++;
        rst = 1'b1;
        exp_acc = 5'b0;
    endtask

    task automatic test_add;
        do_op(1'b0, 32'd5, 32'd7, 32'd0, 5'b00000, 3'b000, 3'b000, 5'd3, 0, 0, 32'd12, 5'b0, 1'b0);
    endtask

    task automatic test_mul_stall;
        do_op(1'b0, 32'd5, 32'd7, 32'd0, 5'b10000, 3'b000, 3'b000, 5'd9, 2, 3, 32'h00000023, 5'b0, 1'b0);
    endtask

    task automatic test_dyn_rm;
        do_op(1'b1, 32'h3f800000, 32'h40000000, 32'd0, 5'b00000, 3'b111, 3'b001, 5'd4, 1, 0,
              32'h40400000, 5'b00000, 1'b0);
    endtask

    task automatic test_illegal;
        do_op(1'b1, 32'h12345678, 32'h9abcdef0, 32'd1, 5'b00001, 3'b111, 3'b101, 5'd17, 0, 1,
              32'hffffffff, 5'b11111, 1'b0);
        do_op(1'b1, 32'h1, 32'h2, 32'h3, 5'b00010, 3'b110, 3'b000, 5'd18, 0, 0,
              32'h1, 5'b00001, 1'b0);
    endtask

    task automatic test_fflags;
        do_op(1'b1, 32'h1, 32'h2, 32'h0, 5'b00000, 3'b000, 3'b000, 5'd1, 0, 0, 32'h11, 5'b00001, 1'b0);
        do_op(1'b1, 32'h3, 32'h4, 32'h0, 5'b00000, 3'b010, 3'b000, 5'd2, 1, 0, 32'h22, 5'b10000, 1'b0);
        total_cnt++;
        if (fflags_acc !== 5'b10001)
            $display("FAIL fflags_or: got %b expected 10001", fflags_acc);
        else pass_cnt++;
        do_op(1'b1, 32'h5, 32'h6, 32'h0, 5'b00000, 3'b001, 3'b000, 5'd3, 0, 1, 32'h33, 5'b00100, 1'b1);
        total_cnt++;
        if (fflags_acc !== 5'b00100)
            $display("FAIL fflags_clr_acc: got %b expected 00100", fflags_acc);
        else pass_cnt++;
    endtask

    task automatic test_flush_exec;
        logic [31:0] a, b;
        a = 32'd100; b = 32'd7;
        drive_issue(1'b1, a, b, 32'd0, 5'b10100, 3'b000, 3'b000, 5'd12);
        flush = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            total_cnt++;
            if ({busy, out_valid, in_ready, alu_float_inst, alu_data1, alu_data2, alu_sel}
                !== {1'b1, 1'b0, 1'b0, 1'b1, a, b, 5'b10100})
                $display("FAIL drain_hold[%0d]: got busy=%b ov=%b rdy=%b af=%b d1=%h d2=%h sel=%h expected busy=1 ov=0 rdy=0 af=1 d1=%h d2=%h sel=14",
                         k, busy, out_valid, in_ready, alu_float_inst, alu_data1, alu_data2, alu_sel, a, b);
            else pass_cnt++;
            flush = (k == 0);
            alu_done = (k == 2);
            alu_result = 32'd14;
            alu_flags = 5'b11111;
            @(negedge clk);
        end
        alu_done = 1'b0; flush = 1'b0;
        total_cnt++;
        if ({busy, out_valid, in_ready, fflags_acc, alu_sel} !== {1'b0, 1'b0, 1'b1, exp_acc, 5'b0})
            $display("FAIL drain_exit: got busy=%b ov=%b rdy=%b acc=%b sel=%h expected busy=0 ov=0 rdy=1 acc=%b sel=0",
                     busy, out_valid, in_ready, fflags_acc, alu_sel, exp_acc);
        else pass_cnt++;
    endtask

    task automatic test_flush_resp;
        drive_issue(1'b1, 32'd9, 32'd9, 32'd0, 5'b00000, 3'b000, 3'b000, 5'd21);
        alu_done = 1'b1; alu_result = 32'd18; alu_flags = 5'b01000;
        @(negedge clk);
        alu_done = 1'b0;
        total_cnt++;
        if ({out_valid, out_result} !== {1'b1, 32'd18})
            $display("FAIL flush_resp_pre: got ov=%b res=%h expected ov=1 res=12", out_valid, out_result);
        else pass_cnt++;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total_cnt++;
        if ({out_valid, in_ready, fflags_acc} !== {1'b0, 1'b1, exp_acc})
            $display("FAIL flush_resp: got ov=%b rdy=%b acc=%b expected ov=0 rdy=1 acc=%b",
                     out_valid, in_ready, fflags_acc, exp_acc);
        else pass_cnt++;
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            logic        fl;
            logic [31:0] a, b, c;
            logic [4:0]  sel;
            fl  = 1'($urandom);
            a   = $urandom; b = $urandom; c = $urandom;
            sel = 5'($urandom);
            do_op(fl, a, b, c, sel, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  5'($urandom), $urandom_range(0, 4), $urandom_range(0, 3),
                  alu_ref(sel, a, b, c), 5'($urandom), ($urandom_range(0, 7) == 0));
        end
        @(negedge clk);
        fflags_clr = 1'b1;
        @(negedge clk);
        fflags_clr = 1'b0;
        exp_acc = 5'b0;
        total_cnt++;
        if (fflags_acc !== 5'b0)
            $display("FAIL idle_clr: got %b expected 00000", fflags_acc);
        else pass_cnt++;
        do_op(1'b1, 32'd1, 32'd1, 32'd0, 5'b0, 3'b0, 3'b0, 5'd5, 0, 0, 32'd2, 5'b00010, 1'b0);
    endtask

    task automatic test_timeout;
        drive_issue(1'b1, 32'd3, 32'd4, 32'd0, 5'b10101, 3'b000, 3'b000, 5'd30);
        for (int k = 0; k < TMO; k++) begin
            total_cnt++;
            if ({busy, out_valid, alu_float_inst} !== 3'b101)
                $display("FAIL timeout_wait[%0d]: got busy/ov/af=%b expected 101", k,
                         {busy, out_valid, alu_float_inst});
            else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++;
        if ({out_valid, out_timeout, out_result, out_flags, out_tag}
            !== {1'b1, 1'b1, 32'b0, 5'b0, 5'd30})
            $display("FAIL timeout: got ov=%b to=%b res=%h flg=%b tag=%h expected ov=1 to=1 res=0 flg=0 tag=1e",
                     out_valid, out_timeout, out_result, out_flags, out_tag);
        else pass_cnt++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total_cnt++;
        if ({in_ready, fflags_acc} !== {1'b1, exp_acc})
            $display("FAIL timeout_done: got rdy=%b acc=%b expected rdy=1 acc=%b", in_ready, fflags_acc, exp_acc);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        drive_issue(1'b1, 32'hdeadbeef, 32'h0badf00d, 32'h1, 5'b00011, 3'b010, 3'b000, 5'd7);
        total_cnt++;
        if ({alu_float_inst, alu_data1} !== {1'b1, 32'hdeadbeef})
            $display("FAIL pre_reset: got af=%b d1=%h expected af=1 d1=deadbeef", alu_float_inst, alu_data1);
        else pass_cnt++;
        #1 rst = 1'b0;
        #1;
        exp_acc = 5'b0;
        total_cnt++;
        if ({busy, in_ready, out_valid, alu_float_inst, alu_data1, alu_data2, alu_data3, alu_sel,
             alu_rm, out_result, out_flags, fflags_acc, out_illegal, out_timeout, out_tag}
            !== {1'b0, 1'b1, 1'b0, 1'b0, 32'b0, 32'b0, 32'b0, 5'b0, 3'b0, 32'b0, 5'b0, 5'b0,
                 1'b0, 1'b0, 5'b0})
            $display("FAIL reset_mid: got busy=%b rdy=%b ov=%b af=%b d1=%h sel=%h rm=%h acc=%b tag=%h expected busy=0 rdy=1 others 0",
                     busy, in_ready, out_valid, alu_float_inst, alu_data1, alu_sel, alu_rm, fflags_acc, out_tag);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        do_op(1'b0, 32'd2, 32'd3, 32'd0, 5'b0, 3'b0, 3'b0, 5'd8, 0, 0, 32'd5, 5'b0, 1'b0);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b0; in_valid = 1'b0; in_float = 1'b0;
        in_data1 = '0; in_data2 = '0; in_data3 = '0;
        in_alusel = '0; in_rm = '0; in_tag = '0; frm_csr = '0;
        flush = 1'b0; alu_result = '0; alu_flags = '0; alu_done = 1'b0;
        out_ready = 1'b0; fflags_clr = 1'b0;

        test_reset();
        test_add();
        test_mul_stall();
        test_dyn_rm();
        test_illegal();
        test_fflags();
        test_flush_exec();
        test_flush_resp();
        test_random();
        test_timeout();
        test_reset_mid();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Execute-stage issue controller directly upstream of the integer/FP ALU (alu_logic).
- Accepts one decoded operation from decode through a valid/ready handshake and registers its operands.
- Holds the ALU inputs stable until the ALU asserts done, then captures result and flags and presents them to writeback through a valid/ready handshake.
- Also resolves the dynamic rounding mode, accumulates FP exception flags, and handles flush and timeout.

Parameters:
- TIMEOUT_CYCLES, 64: maximum EXEC cycles before abort; counter width is $clog2(TIMEOUT_CYCLES+1).
- TAG_W, 5: width of the destination-register tag carried alongside the operation.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  decode has an operation
- in_ready  out  1  controller can accept; high only in IDLE
- in_float  in  1  floating-point operation
- in_data1, in_data2, in_data3  in  32 each  operands
- in_alusel  in  5  {func7[0], func7[5], func3}
- in_rm  in  3  instruction rounding mode; 3'b111 means dynamic
- in_tag  in  TAG_W  destination tag
- frm_csr  in  3  fcsr.frm
- flush  in  1  pipeline flush
- alu_float_inst  out  1  ALU float select
- alu_data1, alu_data2, alu_data3  out  32 each  ALU operands
- alu_sel  out  5  ALU operation select
- alu_rm  out  3  resolved rounding mode
- alu_result  in  32  ALU result
- alu_flags  in  5  ALU FP flags (NV,DZ,OF,UF,NX)
- alu_done  in  1  ALU done
- out_valid  out  1  result available to writeback
- out_ready  in  1  writeback accepts
- out_result  out  32  captured result
- out_tag  out  TAG_W  destination tag
- out_flags  out  5  flags of this operation
- out_illegal  out  1  illegal rounding mode
- out_timeout  out  1  operation timed out
- fflags_acc  out  5  sticky accumulated flags
- fflags_clr  in  1  clear the accumulator
- busy  out  1  state is not IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All operand, result, tag, flag and counter registers = 0.
  - out_valid=0, out_illegal=0, out_timeout=0, fflags_acc=0, busy=0.
- ALU drive by state:
  - In EXEC and DRAIN: alu_* outputs = registered operands.
  - In IDLE and RESP: alu_float_inst=0, alu_sel=0, alu_data*=0, alu_rm=0. This forces all ALU start strobes low, so every op sees at least one non-start cycle before the next issue.
- States: IDLE, EXEC, DRAIN, RESP.
- IDLE:
  - in_ready=1.
  - On in_valid, register operands, sel, float and tag.
  - Rounding mode: rm_res = (in_rm==3'b111) ? frm_csr : in_rm.
  - If in_float and rm_res is 101, 110 or 111: set illegal, result=0, flags=0, go to RESP without issuing.
  - Otherwise clear the timeout counter and go to EXEC.
  - rm is ignored and never illegal for integer ops.
- EXEC:
  - Counter increments each cycle.
  - If alu_done: capture alu_result, and alu_flags when float (else flags=0); go to RESP.
  - Else if flush: go to DRAIN.
  - Else if counter == TIMEOUT_CYCLES-1: result=0, flags=0, timeout=1, go to RESP.
  - alu_done takes priority over flush and timeout in the same cycle.
- DRAIN:
  - Operands stay held until alu_done, then go to IDLE.
  - Result and flags are discarded; no out_valid; fflags_acc is unchanged.
  - Further flush is ignored.
- RESP:
  - out_valid=1; outputs stable until out_valid & out_ready, then go to IDLE.
  - If flush arrives before the handshake: drop to IDLE, out_valid=0, no flag accumulation.
- Latency: a single-cycle op accepted in cycle 0 is in EXEC in cycle 1 with alu_done=1, and out_valid=1 in cycle 2. Throughput is at most one op per 3 cycles.
- fflags_acc:
  - On the RESP handshake of a float op, fflags_acc |= out_flags.
  - fflags_clr clears it; if clear and accumulate occur in the same cycle, the result is exactly the new out_flags.
- busy = (state != IDLE).
- A reset asserted mid-operation returns to IDLE immediately; the ALU sees idle drive.

Test Plan:
- ADD int: data1=5, data2=7, alusel=0, out_ready=1 → out_result=12, out_valid in cycle 2, out_flags=0, then in_ready=1.
- MUL with alu_done delayed 2 cycles, out_ready=0 for 3 cycles:
  - alu_data* held throughout EXEC.
  - out_result=0x00000023 (5×7) held stable until out_ready.
  - alu_sel returns to 0 in RESP.
- FP op with in_rm=111 and frm_csr=001 → alu_rm=001.
- FP op with frm_csr=101 → out_illegal=1, out_result=0, alu_float_inst never asserted.
- FP ops returning flags 5'b00001 then 5'b10000 → fflags_acc=5'b10001; fflags_clr asserted together with a third op's handshake carrying flags 00100 → fflags_acc=00100.
- Flush in EXEC of a DIV:
  - Stays in DRAIN with operands held until alu_done, then IDLE.
  - No out_valid; fflags_acc unchanged.
- alu_done held 0 with TIMEOUT_CYCLES=8 → out_timeout=1 after 8 EXEC cycles, out_result=0; rst low mid-EXEC → all outputs 0 at once.
